pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and fetch-request sequencer for the SingleCycle core.
- Drives pc_o to the PC+4 adder and to instruction memory, then takes the adder's result back on pc_plus4_i.
- Selects the next PC from sequential, branch or jump sources.
- Holds the PC across instruction-memory wait states and pipeline stalls.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect; used only when the optional feature is compiled in.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_o  output  XLEN  current PC; goes to the adder op1 and to the imem address.
- pc_plus4_i  input  XLEN  adder result (pc_o + 4).
- imem_req_o  output  1  fetch request; pc_o is the address.
- imem_ready_i  input  1  imem accepted the request and returned the instruction this cycle.
- pc_valid_o  output  1  pulses for one cycle when the instruction at pc_o is delivered.
- stall_i  input  1  downstream stall; freezes the PC and suppresses the request.
- branch_taken_i  input  1  conditional branch resolved taken.
- branch_target_i  input  XLEN  branch target.
- jump_i  input  1  unconditional jump (JAL/JALR).
- jump_target_i  input  XLEN  jump target.
- misalign_o  output  1  one-cycle pulse on a misaligned redirect target.

Behaviour:
- Reset (asynchronous, any state):
  - pc_o = RESET_VECTOR, state = BOOT.
  - imem_req_o = 0, pc_valid_o = 0, misalign_o = 0.
  - Pending-redirect register is cleared.
- FSM states: BOOT, FETCH, HOLD.
- BOOT:
  - imem_req_o = 0.
  - Goes to FETCH on the next clock. This gives one dead cycle after reset deassertion.
- FETCH:
  - imem_req_o = !stall_i.
  - On imem_ready_i=1 with stall_i=0, pc_valid_o = 1 that cycle, and pc_o updates at the clock edge to the next-PC.
  - Zero-wait memory therefore gives one instruction per cycle.
  - If stall_i=1, go to HOLD.
- HOLD:
  - imem_req_o = 0 and pc_o is frozen.
  - Return to FETCH when stall_i=0.
- Next-PC priority: jump_i > branch_taken_i > pc_plus4_i.
- Redirect while imem_ready_i=0 or while in HOLD:
  - The target is latched into the pending register.
  - A newer redirect overwrites an older one; jump still wins if both arrive in the same cycle.
  - On the next completed handshake, the pending target replaces pc_plus4_i and the register clears.
- Redirect in the same cycle as a completed handshake applies directly.
- Arithmetic:
  - No internal increment; the sequential path uses pc_plus4_i only.
  - Wrap from 32'hFFFF_FFFC to 0 is whatever the adder produces; it is not flagged.
- Stall and handshake in the same cycle: the stall wins. No pc_valid_o pulse is produced, and imem must re-deliver after the stall.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with bits [1:0] != 0 loads TRAP_VECTOR instead of the target.
  - misalign_o pulses for one cycle, aligned with the PC update.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - misalign_o is tied to 0.

Decomposition:
- Package pc_pkg:
  - fetch_state_t enum (BOOT, FETCH, HOLD).
  - Constant PC_ALIGN_BITS = 2.
  - Default RESET_VECTOR and TRAP_VECTOR constants.
- Sub-module pc_next_mux:
  - Purely combinational.
  - Priority select of jump, branch, pending and sequential sources, plus the alignment check and fix.
  - Instantiated once.

Test Plan:
1. Reset, then imem_ready_i held at 1:
   - pc_o = 0 during BOOT.
   - pc_valid_o pulses with pc_o = 0, 4, 8, 12 on consecutive cycles.
2. imem_ready_i low for 3 cycles at pc_o = 8:
   - pc_o holds 8, imem_req_o stays 1.
   - On ready, pc_valid_o pulses and pc_o becomes 12.
3. Same cycle: jump_i = 1 with target 0x200, and branch_taken_i = 1 with target 0x100, handshake completing:
   - Next pc_o = 0x200.
4. branch_taken_i = 1 with target 0x40 during a wait state, then ready 2 cycles later:
   - Next pc_o = 0x40, not pc+4.
5. stall_i = 1 for 4 cycles at pc_o = 0x10:
   - imem_req_o = 0 and pc_o = 0x10 throughout.
   - Fetch resumes at 0x10.
6. Jump to 0x202 with PC_MISALIGN_TRAP_EN defined:
   - pc_o = 0x100, misalign_o pulses once.
   - Without the macro: pc_o = 0x200, misalign_o = 0.
7. Assert rst mid-wait at pc_o = 0x40:
   - pc_o = 0 immediately.
   - Pending redirect is cleared and state is BOOT.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int PC_ALIGN_BITS = 2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select (jump > branch > pending > sequential) with target alignment.
// PC_MISALIGN_TRAP_EN: misaligned targets load TRAP_VECTOR and raise misalign; otherwise low bits are cleared.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << PC_ALIGN_BITS) - 1);

  logic            sel_valid;
  logic [XLEN-1:0] sel_target;

  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
    // A fresh redirect this cycle outranks an older pending one.
    sel_valid       = redirect | pend_valid;
    sel_target      = redirect ? redirect_target : pend_target;
    next_pc         = pc_plus4;
    misalign        = 1'b0;
    if (sel_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (|(sel_target & ALIGN_MASK)) begin
        next_pc  = TRAP_VECTOR;
        misalign = 1'b1;
      end else begin
        next_pc = sel_target;
      end
`else
      next_pc = sel_target & ~ALIGN_MASK;
`endif
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-request sequencer (BOOT -> FETCH <-> HOLD), fsm_state exposes the FSM.
// PC_MISALIGN_TRAP_EN enables trapping on misaligned redirect targets.
// Handshake: imem_req_o asks for the instruction at pc_o; a transfer completes in a cycle with
// imem_req_o=1 and imem_ready_i=1, signalled by pc_valid_o, and pc_o advances at that clock edge.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            imem_req_o,
  input  logic            imem_ready_i,
  output logic            pc_valid_o,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            misalign_o,
  output logic [1:0]      fsm_state
);

  fetch_state_t    state, state_next;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] next_pc;
  logic            next_misalign;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  pc_next_mux #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_mux (
    .jump            (jump_i),
    .jump_target     (jump_target_i),
    .branch_taken    (branch_taken_i),
    .branch_target   (branch_target_i),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .pc_plus4        (pc_plus4_i),
    .next_pc         (next_pc),
    .misalign        (next_misalign),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  always_comb begin
    state_next = state;
    imem_req_o = 1'b0;
    pc_valid_o = 1'b0;
    case (state)
      BOOT: state_next = FETCH;
      FETCH: begin
        imem_req_o = ~stall_i;
        pc_valid_o = imem_ready_i & ~stall_i;
        if (stall_i) state_next = HOLD;
      end
      HOLD: if (!stall_i) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_o        <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      misalign_o  <= 1'b0;
    end else begin
      state      <= state_next;
      misalign_o <= 1'b0;
      if (pc_valid_o) begin
        pc_o       <= next_pc;
        pend_valid <= 1'b0;
        misalign_o <= next_misalign;
      end else if (redirect) begin
        // Redirect arrived without a completed transfer: keep it for the next one.
        pend_valid  <= 1'b1;
        pend_target <= redirect_target;
      end
    end
  end

  assign fsm_state = state;

endmodule
